// File: rtl/uart_hex_stream_tx.sv
// Buffered UART transmitter that prints each sample as a line of ASCII hex digits.
// Samples queue in a small FIFO so capture can continue while a line is on the wire.
module uart_hex_stream_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 40,
    parameter int FIFO_DEPTH = 4,
    parameter bit LOWERCASE  = 1'b0,
    parameter bit CRLF       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            drop_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int NHEX         = DATA_WIDTH / 4;
    localparam int NCHAR        = NHEX + 1 + (CRLF ? 1 : 0);
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = $clog2(NCHAR);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NCHAR - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else if (LOWERCASE) begin
            return 8'h57 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    // Index 0 is the most-significant nibble; indices past the digits are the terminator.
    function automatic logic [7:0] char_at(input logic [DATA_WIDTH-1:0] word,
                                           input logic [IW-1:0]         idx);
        logic [DATA_WIDTH-1:0] shifted;
        shifted = word;
        if (int'(idx) < NHEX) begin
            shifted = word >> (4 * (NHEX - 1 - int'(idx)));
            return hex_ascii(shifted[3:0]);
        end else if (CRLF && int'(idx) == NHEX) begin
            return 8'h0D;
        end else begin
            return 8'h0A;
        end
    endfunction

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;
    logic [7:0]            sh_q, sh_d;
    logic                  tx_q, tx_d;
    logic [7:0]            drop_q, drop_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, wr_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [AW:0]           cnt_q, cnt_d;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == FIFO_FULL);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_q];
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign drop_count = drop_q;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = in_data;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (in_valid && !in_ready && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        line_d    = line_q;
        sh_d      = sh_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    line_d    = head;
                    idx_d     = '0;
                    sh_d      = char_at(head, '0);
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    bit_d     = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    // Next character starts immediately; only a finished line returns to IDLE.
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        sh_d    = char_at(line_q, idx_q + IW'(1));
                        state_d = S_START;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        if (state_q == S_START) begin
            tx_d = 1'b0;
        end else if (state_q == S_DATA) begin
            tx_d = sh_q[bit_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_q     <= 3'd0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            drop_q    <= 8'd0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            drop_q    <= drop_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    // Payload storage needs no reset: it is only read once the control state says it is valid.
    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        line_q <= line_d;
        sh_q   <= sh_d;
    end

endmodule

// File: tb/tb_uart_hex_stream_tx.sv
// Bench for uart_hex_stream_tx: two configurations, a UART receiver per line and a
// string-level model of the printed lines and their start-bit times.
module tb_uart_hex_stream_tx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] in_data_a;
    logic        in_valid_a, in_ready_a, tx_a, busy_a;
    logic [7:0]  drop_a;
    logic [7:0]  in_data_b;
    logic        in_valid_b, in_ready_b, tx_b, busy_b;
    logic [7:0]  drop_b;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int fe_a = 0;
    int fe_b = 0;

    logic [7:0] rxa_byte[$];
    int         rxa_time[$];
    logic [7:0] rxb_byte[$];
    int         rxb_time[$];
    logic [7:0] exp_byte[$];
    int         exp_time[$];

    uart_hex_stream_tx #(.CLK_FREQ(16), .BAUD(1), .DATA_WIDTH(40), .FIFO_DEPTH(4),
                         .LOWERCASE(1'b0), .CRLF(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a), .drop_count(drop_a));

    uart_hex_stream_tx #(.CLK_FREQ(16), .BAUD(1), .DATA_WIDTH(8), .FIFO_DEPTH(2),
                         .LOWERCASE(1'b1), .CRLF(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .drop_count(drop_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : mon_a
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (tx_a === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) @(negedge clk);
                if (tx_a !== 1'b0) fe_a++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_a;
                end
                repeat (CPB) @(negedge clk);
                if (tx_a !== 1'b1) fe_a++;
                rxa_byte.push_back(b);
                rxa_time.push_back(t);
            end
        end
    end

    initial begin : mon_b
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (tx_b === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) @(negedge clk);
                if (tx_b !== 1'b0) fe_b++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_b;
                end
                repeat (CPB) @(negedge clk);
                if (tx_b !== 1'b1) fe_b++;
                rxb_byte.push_back(b);
                rxb_time.push_back(t);
            end
        end
    end

    // Reference: one line = hex digits MS nibble first, then terminator; frames abut,
    // and one idle cycle separates consecutive lines.
    task automatic add_line(input logic [63:0] s, input int nhex, input bit lower,
                            input bit crlf, inout int t);
        string dig;
        int nib;
        if (lower) dig = "0123456789abcdef";
        else       dig = "0123456789ABCDEF";
        for (int i = nhex - 1; i >= 0; i--) begin
            nib = int'((s >> (4 * i)) & 64'hF);
            exp_byte.push_back(dig[nib]);
            exp_time.push_back(t);
            t += FRAME;
        end
        if (crlf) begin
            exp_byte.push_back(8'h0D);
            exp_time.push_back(t);
            t += FRAME;
        end
        exp_byte.push_back(8'h0A);
        exp_time.push_back(t);
        t += FRAME + 1;
    endtask

    task automatic clear_q();
        rxa_byte.delete(); rxa_time.delete();
        rxb_byte.delete(); rxb_time.delete();
        exp_byte.delete(); exp_time.delete();
    endtask

    task automatic wait_na(input int n);
        int k = 0;
        while (rxa_byte.size() < n && k < n * (FRAME + 2) + 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_nb(input int n);
        int k = 0;
        while (rxb_byte.size() < n && k < n * (FRAME + 2) + 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy_a === 1'b1 || busy_b === 1'b1) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid_a = 1'b0; in_data_a = '0;
        in_valid_b = 1'b0; in_data_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (tx_a !== 1'b1) $display("FAIL reset tx_a: got %b want 1", tx_a); else pass_cnt++;
        total_cnt++; if (in_ready_a !== 1'b1) $display("FAIL reset in_ready_a: got %b want 1", in_ready_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset busy_a: got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (drop_a !== 8'd0) $display("FAIL reset drop_a: got %0d want 0", drop_a); else pass_cnt++;
        total_cnt++; if (tx_b !== 1'b1) $display("FAIL reset tx_b: got %b want 1", tx_b); else pass_cnt++;
        total_cnt++; if (in_ready_b !== 1'b1) $display("FAIL reset in_ready_b: got %b want 1", in_ready_b); else pass_cnt++;
        total_cnt++; if (busy_b !== 1'b0) $display("FAIL reset busy_b: got %b want 0", busy_b); else pass_cnt++;
        total_cnt++; if (drop_b !== 8'd0) $display("FAIL reset drop_b: got %0d want 0", drop_b); else pass_cnt++;
    endtask

    task automatic test_single_line();
        int c, t, n;
        clear_q();
        c = cyc;
        in_data_a = 40'h00DEADBEEF;
        in_valid_a = 1'b1;
        total_cnt++; if (in_ready_a !== 1'b1) $display("FAIL single ready: got %b want 1", in_ready_a); else pass_cnt++;
        @(negedge clk);
        in_valid_a = 1'b0;
        t = c + 3;
        add_line(64'h00DEADBEEF, 10, 1'b0, 1'b0, t);
        n = 0;
        while (busy_a === 1'b1 && n < 4000) begin
            n++;
            @(negedge clk);
        end
        total_cnt++; if (n != 1761) $display("FAIL single busy_len: got %0d want 1761", n); else pass_cnt++;
        wait_na(exp_byte.size());
        total_cnt++;
        if (rxa_byte.size() != exp_byte.size()) $display("FAIL single count: got %0d want %0d", rxa_byte.size(), exp_byte.size());
        else pass_cnt++;
        for (int i = 0; i < exp_byte.size() && i < rxa_byte.size(); i++) begin
            total_cnt++;
            if (rxa_byte[i] !== exp_byte[i] || rxa_time[i] != exp_time[i])
                $display("FAIL single byte%0d: got %h@%0d want %h@%0d", i, rxa_byte[i], rxa_time[i], exp_byte[i], exp_time[i]);
            else pass_cnt++;
        end
        wait_idle();
    endtask

    task automatic test_burst();
        logic [63:0] r;
        logic [39:0] d;
        logic [39:0] acc[$];
        int c, t;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        clear_q();
        c = cyc;
        for (int i = 0; i < 6; i++) begin
            r = {$urandom(), $urandom()};
            d = r[39:0];
            in_data_a = d;
            in_valid_a = 1'b1;
            total_cnt++;
            if (in_ready_a !== (i < 5)) $display("FAIL burst ready%0d: got %b want %b", i, in_ready_a, (i < 5));
            else pass_cnt++;
            if (i < 5) acc.push_back(d);
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        total_cnt++; if (drop_a !== 8'd1) $display("FAIL burst drop: got %0d want 1", drop_a); else pass_cnt++;
        t = c + 3;
        foreach (acc[k]) add_line({24'h0, acc[k]}, 10, 1'b0, 1'b0, t);
        wait_na(exp_byte.size());
        total_cnt++;
        if (rxa_byte.size() != exp_byte.size()) $display("FAIL burst count: got %0d want %0d", rxa_byte.size(), exp_byte.size());
        else pass_cnt++;
        for (int i = 0; i < exp_byte.size() && i < rxa_byte.size(); i++) begin
            total_cnt++;
            if (rxa_byte[i] !== exp_byte[i] || rxa_time[i] != exp_time[i])
                $display("FAIL burst byte%0d: got %h@%0d want %h@%0d", i, rxa_byte[i], rxa_time[i], exp_byte[i], exp_time[i]);
            else pass_cnt++;
        end
        wait_idle();
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL burst idle busy: got %b want 0", busy_a); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [63:0] r;
        logic [39:0] d;
        logic [7:0]  ch;
        int c, t, target, k, lows;
        total_cnt++; if (drop_a !== 8'd1) $display("FAIL midrst drop_before: got %0d want 1", drop_a); else pass_cnt++;
        clear_q();
        r = {$urandom(), $urandom()};
        d = r[39:0];
        c = cyc;
        in_data_a = d;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        t = c + 3;
        add_line({24'h0, d}, 10, 1'b0, 1'b0, t);
        ch = exp_byte[2];
        target = c + 3 + 2 * FRAME + 5 * CPB + CPB / 2;
        k = 0;
        while (cyc < target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        total_cnt++; if (tx_a !== ch[4]) $display("FAIL midrst bit4: got %b want %b", tx_a, ch[4]); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (tx_a !== 1'b1) $display("FAIL midrst tx: got %b want 1", tx_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL midrst busy: got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (in_ready_a !== 1'b1) $display("FAIL midrst ready: got %b want 1", in_ready_a); else pass_cnt++;
        total_cnt++; if (drop_a !== 8'd0) $display("FAIL midrst drop: got %0d want 0", drop_a); else pass_cnt++;
        lows = 0;
        repeat (250) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        total_cnt++; if (lows != 0) $display("FAIL midrst quiet: got %0d active cycles want 0", lows); else pass_cnt++;

        // Reset wins over a push offered on the same edge.
        rst = 1'b1;
        in_data_a = 40'h5A5A5A5A5A;
        in_valid_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid_a = 1'b0;
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        total_cnt++; if (lows != 0) $display("FAIL rstprio quiet: got %0d active cycles want 0", lows); else pass_cnt++;

        clear_q();
        c = cyc;
        in_data_a = 40'h1;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        t = c + 3;
        add_line(64'h1, 10, 1'b0, 1'b0, t);
        wait_na(exp_byte.size());
        total_cnt++;
        if (rxa_byte.size() != exp_byte.size()) $display("FAIL midrst count: got %0d want %0d", rxa_byte.size(), exp_byte.size());
        else pass_cnt++;
        for (int i = 0; i < exp_byte.size() && i < rxa_byte.size(); i++) begin
            total_cnt++;
            if (rxa_byte[i] !== exp_byte[i] || rxa_time[i] != exp_time[i])
                $display("FAIL midrst byte%0d: got %h@%0d want %h@%0d", i, rxa_byte[i], rxa_time[i], exp_byte[i], exp_time[i]);
            else pass_cnt++;
        end
        wait_idle();
    endtask

    task automatic test_drop_saturate();
        logic [63:0] r;
        logic [39:0] d;
        logic [39:0] acc[$];
        int c, t;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        clear_q();
        c = cyc;
        for (int i = 0; i < 305; i++) begin
            if (i == 105) begin
                total_cnt++; if (drop_a !== 8'd100) $display("FAIL sat drop_mid: got %0d want 100", drop_a); else pass_cnt++;
            end
            r = {$urandom(), $urandom()};
            d = r[39:0];
            in_data_a = d;
            in_valid_a = 1'b1;
            total_cnt++;
            if (in_ready_a !== (i < 5)) $display("FAIL sat ready%0d: got %b want %b", i, in_ready_a, (i < 5));
            else pass_cnt++;
            if (i < 5) acc.push_back(d);
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        total_cnt++; if (drop_a !== 8'd255) $display("FAIL sat drop_end: got %0d want 255", drop_a); else pass_cnt++;
        t = c + 3;
        foreach (acc[k]) add_line({24'h0, acc[k]}, 10, 1'b0, 1'b0, t);
        wait_na(exp_byte.size());
        total_cnt++;
        if (rxa_byte.size() != exp_byte.size()) $display("FAIL sat count: got %0d want %0d", rxa_byte.size(), exp_byte.size());
        else pass_cnt++;
        for (int i = 0; i < exp_byte.size() && i < rxa_byte.size(); i++) begin
            total_cnt++;
            if (rxa_byte[i] !== exp_byte[i] || rxa_time[i] != exp_time[i])
                $display("FAIL sat byte%0d: got %h@%0d want %h@%0d", i, rxa_byte[i], rxa_time[i], exp_byte[i], exp_time[i]);
            else pass_cnt++;
        end
        wait_idle();
        total_cnt++; if (drop_a !== 8'd255) $display("FAIL sat drop_hold: got %0d want 255", drop_a); else pass_cnt++;
    endtask

    task automatic test_short_lower_crlf();
        int c, t;
        clear_q();
        c = cyc;
        in_data_b = 8'hA5;
        in_valid_b = 1'b1;
        total_cnt++; if (in_ready_b !== 1'b1) $display("FAIL short ready0: got %b want 1", in_ready_b); else pass_cnt++;
        @(negedge clk);
        in_data_b = 8'h0F;
        total_cnt++; if (in_ready_b !== 1'b1) $display("FAIL short ready1: got %b want 1", in_ready_b); else pass_cnt++;
        @(negedge clk);
        in_valid_b = 1'b0;
        t = c + 3;
        add_line(64'hA5, 2, 1'b1, 1'b1, t);
        add_line(64'h0F, 2, 1'b1, 1'b1, t);
        wait_nb(exp_byte.size());
        total_cnt++;
        if (rxb_byte.size() != exp_byte.size()) $display("FAIL short count: got %0d want %0d", rxb_byte.size(), exp_byte.size());
        else pass_cnt++;
        for (int i = 0; i < exp_byte.size() && i < rxb_byte.size(); i++) begin
            total_cnt++;
            if (rxb_byte[i] !== exp_byte[i] || rxb_time[i] != exp_time[i])
                $display("FAIL short byte%0d: got %h@%0d want %h@%0d", i, rxb_byte[i], rxb_time[i], exp_byte[i], exp_time[i]);
            else pass_cnt++;
        end
        wait_idle();
    endtask

    task automatic test_random_a();
        logic [63:0] r;
        logic [39:0] d;
        logic [39:0] acc[$];
        int c, t, n;
        for (int it = 0; it < 3; it++) begin
            clear_q();
            acc.delete();
            repeat ($urandom_range(0, 7)) @(negedge clk);
            n = int'($urandom_range(1, 3));
            c = cyc;
            for (int i = 0; i < n; i++) begin
                r = {$urandom(), $urandom()};
                d = r[39:0];
                in_data_a = d;
                in_valid_a = 1'b1;
                total_cnt++; if (in_ready_a !== 1'b1) $display("FAIL randa ready%0d: got %b want 1", i, in_ready_a); else pass_cnt++;
                acc.push_back(d);
                @(negedge clk);
            end
            in_valid_a = 1'b0;
            t = c + 3;
            foreach (acc[k]) add_line({24'h0, acc[k]}, 10, 1'b0, 1'b0, t);
            wait_na(exp_byte.size());
            total_cnt++;
            if (rxa_byte.size() != exp_byte.size()) $display("FAIL randa count: got %0d want %0d", rxa_byte.size(), exp_byte.size());
            else pass_cnt++;
            for (int i = 0; i < exp_byte.size() && i < rxa_byte.size(); i++) begin
                total_cnt++;
                if (rxa_byte[i] !== exp_byte[i] || rxa_time[i] != exp_time[i])
                    $display("FAIL randa byte%0d: got %h@%0d want %h@%0d", i, rxa_byte[i], rxa_time[i], exp_byte[i], exp_time[i]);
                else pass_cnt++;
            end
            wait_idle();
            total_cnt++; if (busy_a !== 1'b0) $display("FAIL randa busy: got %b want 0", busy_a); else pass_cnt++;
        end
    endtask

    task automatic test_random_b();
        logic [7:0] d;
        logic [7:0] acc[$];
        int c, t, n;
        for (int it = 0; it < 4; it++) begin
            clear_q();
            acc.delete();
            repeat ($urandom_range(0, 7)) @(negedge clk);
            n = int'($urandom_range(1, 3));
            c = cyc;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom());
                in_data_b = d;
                in_valid_b = 1'b1;
                total_cnt++; if (in_ready_b !== 1'b1) $display("FAIL randb ready%0d: got %b want 1", i, in_ready_b); else pass_cnt++;
                acc.push_back(d);
                @(negedge clk);
            end
            in_valid_b = 1'b0;
            t = c + 3;
            foreach (acc[k]) add_line({56'h0, acc[k]}, 2, 1'b1, 1'b1, t);
            wait_nb(exp_byte.size());
            total_cnt++;
            if (rxb_byte.size() != exp_byte.size()) $display("FAIL randb count: got %0d want %0d", rxb_byte.size(), exp_byte.size());
            else pass_cnt++;
            for (int i = 0; i < exp_byte.size() && i < rxb_byte.size(); i++) begin
                total_cnt++;
                if (rxb_byte[i] !== exp_byte[i] || rxb_time[i] != exp_time[i])
                    $display("FAIL randb byte%0d: got %h@%0d want %h@%0d", i, rxb_byte[i], rxb_time[i], exp_byte[i], exp_time[i]);
                else pass_cnt++;
            end
            wait_idle();
            total_cnt++; if (busy_b !== 1'b0) $display("FAIL randb busy: got %b want 0", busy_b); else pass_cnt++;
        end
    endtask

    task automatic test_framing();
        total_cnt++; if (fe_a != 0) $display("FAIL framing_a: got %0d errors want 0", fe_a); else pass_cnt++;
        total_cnt++; if (fe_b != 0) $display("FAIL framing_b: got %0d errors want 0", fe_b); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_burst();
        test_reset_midframe();
        test_drop_saturate();
        test_short_lower_crlf();
        test_random_a();
        test_random_b();
        test_framing();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_hex_stream_tx.md
# uart_hex_stream_tx

Buffered, parametrised UART transmitter that prints each accepted sample as a fixed-width line of ASCII hex digits followed by a line terminator. Samples arrive from the measurement core through a valid/ready interface into a small FIFO, so a new sample can be captured while a line is still on the wire. Samples offered while the FIFO is full are dropped and counted. The block sits between the time-to-digital capture logic and the board's serial TX pin.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division). Must be ≥ 2.
- DATA_WIDTH, 40: sample width. Must be a multiple of 4, range 4..64. NHEX = DATA_WIDTH/4.
- FIFO_DEPTH, 4: sample buffer entries. Must be a power of two, ≥ 2.
- LOWERCASE, 0: 1 emits 'a'-'f' (0x61-0x66); 0 emits 'A'-'F' (0x41-0x46).
- CRLF, 0: 1 terminates each line with 0x0D 0x0A; 0 terminates with 0x0A only. NCHAR = NHEX + 1 + CRLF.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  sample to print.
- in_valid  in  1  sample offered this cycle.
- in_ready  out  1  FIFO not full; sample accepted on a cycle where in_valid && in_ready.
- tx  out  1  UART TX line, registered, idle high.
- busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- drop_count  out  8  number of samples offered while in_ready was low; saturates at 255.

## Operation
- Reset values: tx=1, in_ready=1, busy=0, drop_count=0; FIFO empty; FSM in IDLE.
- Format: 8N1, LSB first. Each line is NHEX hex digits, most-significant nibble first, leading zeros printed, then the terminator.
- FIFO: push on in_valid && in_ready. Pop only in IDLE when non-empty. in_ready = !full, taken from registered state. A pop in the same cycle does not make a full FIFO accept a push.
- Drops: every cycle with in_valid && !in_ready increments drop_count by 1, up to 255. The offered sample is discarded. drop_count is cleared only by rst.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into the line register, set char index to 0, load character 0, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=byte[bit], for 8 bits of CLKS_PER_BIT cycles each, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If more characters remain in the line, increment the index, load the next character, and go directly to START. If not, go to IDLE.
- Character select: index < NHEX gives a hex digit of the nibble at index. With CRLF=1, index NHEX gives 0x0D. The last index gives 0x0A.
- Counters: bit counter is 3 bits. clk counter is sized to hold CLKS_PER_BIT-1. char index is sized to hold NCHAR-1. No counter wraps while in use.

## Timing
- Latency: a sample accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. tx falls at edge N+2.
- Each bit lasts exactly CLKS_PER_BIT cycles. There are no idle cycles between characters within a line. A frame is 10·CLKS_PER_BIT cycles.
- Line duration is NCHAR·10·CLKS_PER_BIT cycles. Between back-to-back lines there is exactly 1 IDLE cycle with tx=1 before the next start bit.
- busy rises on the edge after the first push and falls on the edge the FSM enters IDLE with the FIFO empty.
- rst asserted mid-frame: tx=1 on the next edge and the partial character is abandoned. FIFO and drop_count are cleared. No further output occurs until a new push.
- rst has priority over a simultaneous push.

## Test plan
All scenarios use CLK_FREQ=16 and BAUD=1 (CLKS_PER_BIT=16) unless stated otherwise.
- Default params, push 40'h00DEADBEEF once: tx decodes to 30 30 44 45 41 44 42 45 45 46 0A. The start bit begins 2 cycles after the push. busy is high for 1761 cycles after the push edge.
- LOWERCASE=1, CRLF=1, same sample: the line is "00deadbeef\r\n" (12 bytes). There is no gap between frames.
- FIFO_DEPTH=4, in_valid held for 6 consecutive cycles starting from idle: 5 accepted, in_ready low on the 6th, drop_count=1. Five lines print in push order with a 1-cycle gap between them.
- DATA_WIDTH=8, push 8'hA5 then 8'h0F: the output is "A5\n0F\n". Check the leading zero and the A-F mapping.
- Assert rst for 1 cycle during bit 4 of the third character: tx=1 on the next edge, busy=0, in_ready=1, drop_count=0. A later push of 40'h1 prints "0000000001\n" cleanly.
- FIFO held full, 300 offers rejected: drop_count saturates at 255 and stays there while lines continue to print.
